// File: rtl/hi_lo_unit_if.sv
// Pipeline/multiplier-side bundle for the HI/LO unit: MULT request, external
// multiplier hookup, MTHI/MTLO writes and the HI/LO/busy/done results.
interface hi_lo_unit_if #(
  parameter int BitWidth = 32
);
  logic                    start;
  logic                    isUnsigned;
  logic [BitWidth-1:0]     operandA;
  logic [BitWidth-1:0]     operandB;
  logic                    mulEnable;
  logic                    mulUnsigned;
  logic [BitWidth-1:0]     mulA;
  logic [BitWidth-1:0]     mulB;
  logic [2*BitWidth-1:0]   product;
  logic                    writeHi;
  logic                    writeLo;
  logic [BitWidth-1:0]     writeData;
  logic [BitWidth-1:0]     hi;
  logic [BitWidth-1:0]     lo;
  logic                    busy;
  logic                    done;

  modport master (
    output start, isUnsigned, operandA, operandB, product,
           writeHi, writeLo, writeData,
    input  mulEnable, mulUnsigned, mulA, mulB, hi, lo, busy, done
  );

  modport slave (
    input  start, isUnsigned, operandA, operandB, product,
           writeHi, writeLo, writeData,
    output mulEnable, mulUnsigned, mulA, mulB, hi, lo, busy, done
  );
endinterface

// File: rtl/hi_lo_unit.sv
// Multi-cycle MULT/MULTU sequencer and HI/LO register pair; drives an external
// combinational multiplier for Latency cycles, then captures its product.
module hi_lo_unit #(
  parameter int BitWidth = 32,
  parameter int Latency  = 4
) (
  input logic          clk,
  input logic          rst_n,
  hi_lo_unit_if.slave  bus
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  localparam logic [3:0] CntLoad = 4'(Latency - 1);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic                  r_unsigned;
  logic [BitWidth-1:0]   r_a;
  logic [BitWidth-1:0]   r_b;
  logic [BitWidth-1:0]   r_hi;
  logic [BitWidth-1:0]   r_lo;
  logic                  r_done;
  logic                  w_cnt_zero;

  assign w_cnt_zero = (r_cnt == 4'd0);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.start) w_next = S_BUSY;
      S_BUSY: if (w_cnt_zero) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_unsigned <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // MTHI/MTLO land even when a multiply starts on the same edge
          if (bus.writeHi) r_hi <= bus.writeData;
          if (bus.writeLo) r_lo <= bus.writeData;
          if (bus.start) begin
            r_unsigned <= bus.isUnsigned;
            r_a        <= bus.operandA;
            r_b        <= bus.operandB;
            r_cnt      <= CntLoad;
          end
        end
        S_BUSY: begin
          if (w_cnt_zero) begin
            r_hi   <= bus.product[2*BitWidth-1:BitWidth];
            r_lo   <= bus.product[BitWidth-1:0];
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state == S_BUSY);
  assign bus.mulEnable   = (r_state == S_BUSY);
  assign bus.mulUnsigned = r_unsigned;
  assign bus.mulA        = r_a;
  assign bus.mulB        = r_b;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.done        = r_done;

endmodule
